// File: rtl/if_prefetch.sv
// if_prefetch: prefetching fetch stage, pipelined memory reads into an in-order PC-tagged FIFO, flushed on branch
module if_prefetch #(
    parameter int unsigned        BITSIZE         = 32,
    parameter int unsigned        FIFO_DEPTH      = 4,
    parameter int unsigned        MAX_OUTSTANDING = 2,
    parameter logic [BITSIZE-1:0] RESET_PC        = '0
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic               fetch_enable_i,
    output logic               if_valid_o,
    input  logic               id_ready_i,
    output logic [31:0]        if_instr_o,
    output logic [BITSIZE-1:0] if_pc_o,
    output logic               mem_read_o,
    output logic [BITSIZE-1:0] mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_valid_i,
    input  logic [31:0]        mem_data_i,
    input  logic               branch_taken_i,
    input  logic [BITSIZE-1:0] pc_i
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             r_state, w_state_next;
    logic [BITSIZE-1:0] r_fetch_pc, r_resp_pc, w_target;
    logic [CW-1:0]      r_out, r_drop, r_cnt, w_out_next, w_drop_next;
    logic [AW-1:0]      r_rd, r_wr;
    logic [31:0]        r_instr [FIFO_DEPTH];
    logic [BITSIZE-1:0] r_pcs [FIFO_DEPTH];
    logic               w_gnt, w_push, w_pop;

    assign w_target    = pc_i & ~BITSIZE'(3);
    assign mem_read_o  = (r_state == FETCH) && !branch_taken_i && (r_out < CW'(MAX_OUTSTANDING))
                         && (({1'b0, r_cnt} + {1'b0, r_out}) < (CW + 1)'(FIFO_DEPTH));
    assign mem_addr_o  = r_fetch_pc;
    assign if_valid_o  = (r_cnt != '0) && !branch_taken_i;
    assign if_instr_o  = r_instr[r_rd];
    assign if_pc_o     = r_pcs[r_rd];
    assign w_gnt       = mem_read_o && mem_gnt_i;
    assign w_pop       = if_valid_o && id_ready_i;
    // responses owed to a pre-branch stream are swallowed until drop count reaches zero
    assign w_push      = mem_valid_i && (r_drop == '0) && !branch_taken_i;
    assign w_out_next  = r_out + CW'(w_gnt) - CW'(mem_valid_i);
    assign w_drop_next = branch_taken_i ? r_out - CW'(mem_valid_i)
                                        : r_drop - CW'(mem_valid_i && (r_drop != '0));

    always_comb begin
        w_state_next = r_state;
        w_state_next = (w_drop_next != '0) ? DRAIN : (fetch_enable_i ? FETCH : IDLE);
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pcs[i]   <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            r_drop  <= w_drop_next;
            if (branch_taken_i) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_cnt      <= '0;
                r_rd       <= '0;
                r_wr       <= '0;
            end else begin
                if (w_gnt)
                    r_fetch_pc <= r_fetch_pc + BITSIZE'(4);
                if (w_push) begin
                    r_instr[r_wr] <= mem_data_i;
                    r_pcs[r_wr]   <= r_resp_pc;
                    r_wr          <= r_wr + AW'(1);
                    r_resp_pc     <= r_resp_pc + BITSIZE'(4);
                end
                if (w_pop)
                    r_rd <= r_rd + AW'(1);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset_i) !(mem_valid_i && (r_out == '0)));

endmodule
